pipe_hazard_ctrl: RTL
=====================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter MULCYC, default 8, the total EX stall cycles for a multi-cycle op (legal range 2..31).
REQ-002 SHALL have parameter BRDELAY, default 1, the extra IF/ID flush cycles after the branch-resolve cycle (legal range 0..7).
REQ-003 SHALL have port CLOCK  in  1  clock; all state updates on the rising edge.
REQ-004 SHALL have port RESET  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports IDRS, IDRT  in  5 each  source register numbers of the instruction in ID.
REQ-006 SHALL have ports EXMEMREAD (in, 1) and EXRT (in, 5): the instruction in EX is a load, and its destination register.
REQ-007 SHALL have port BRTAKEN  in  1  branch/jump resolved taken in EX, level, valid for one cycle.
REQ-008 SHALL have port MEMBUSY  in  1  data memory not ready; freeze the whole pipe.
REQ-009 SHALL have port MULSTART  in  1  multi-cycle op entering EX, one-cycle pulse.
REQ-010 SHALL have port PCHOLD  out  1  PC keeps its value.
REQ-011 SHALL have port IFIDWRITE  out  1  IF/ID hold; 1 = keep contents.
REQ-012 SHALL have port IFFLASH  out  1  IF/ID clear to zero.
REQ-013 SHALL have ports IDEXHOLD (out, 1) and IDEXFLUSH (out, 1): ID/EX hold, and ID/EX bubble insert.
REQ-014 SHALL have port EXMEMFLUSH  out  1  EX/MEM bubble insert.
REQ-015 SHALL have ports BUSY (out, 1) = state != RUN, and STALLCNT (out, 16) = stall-cycle counter.

Function
REQ-016 SHALL keep a state register with states RUN, FLUSH and MULWAIT, plus a 5-bit down-counter CNT.
REQ-017 SHALL drive all control outputs combinationally from the current state, CNT and the current inputs, with zero-cycle latency.
REQ-018 SHALL define load-use (LU) as EXMEMREAD & (EXRT != 0) & ((EXRT == IDRS) | (EXRT == IDRT)).
REQ-019 SHALL, in RUN, evaluate conditions in this priority order: MEMBUSY > BRTAKEN > LU > MULSTART.
REQ-020 SHALL, in RUN with MEMBUSY, assert PCHOLD, IFIDWRITE, IDEXHOLD and hold state; all other requests that cycle are ignored.
REQ-021 SHALL, in RUN with BRTAKEN, assert IFFLASH and IDEXFLUSH; if BRDELAY > 0, go to FLUSH with CNT = BRDELAY-1, else stay in RUN.
REQ-022 SHALL, in RUN with LU, assert PCHOLD, IFIDWRITE and IDEXFLUSH for exactly that cycle and stay in RUN.
REQ-023 SHALL, in RUN with MULSTART, go to MULWAIT with CNT = MULCYC-2; the MULSTART cycle itself asserts no stall.
REQ-024 SHALL, in FLUSH, assert IFFLASH; BRTAKEN, LU and MULSTART are ignored; when CNT == 0 go to RUN, else CNT decrements.
REQ-025 SHALL, in MULWAIT, assert PCHOLD, IFIDWRITE, IDEXHOLD and EXMEMFLUSH; when CNT == 0 go to RUN, else CNT decrements.
REQ-026 SHALL, on MEMBUSY in FLUSH or MULWAIT, add the freeze outputs of REQ-020 to that state's outputs, hold CNT and hold state.
REQ-027 SHALL never assert IFFLASH and IFIDWRITE together; IFFLASH wins.
REQ-028 SHALL increment STALLCNT in every cycle with PCHOLD = 1, saturating at 16'hFFFF without wrap.

Reset
REQ-029 SHALL, while RESET = 0, force state = RUN, CNT = 0, STALLCNT = 0 and all control outputs and BUSY to 0, immediately and regardless of CLOCK.
REQ-030 SHALL abort an in-progress FLUSH or MULWAIT on reset with no residual stall afterwards; the first cycle after release evaluates as RUN.

Configuration
REQ-031 SHALL, with macro PIPE_MULDIV_STALL_EN defined, implement MULWAIT and REQ-023/025 as written.
REQ-032 SHALL, without PIPE_MULDIV_STALL_EN: ignore MULSTART, make MULWAIT unreachable, tie EXMEMFLUSH to 0, and cap CNT at 3 bits.

Verification
REQ-033 SHALL cover: EXMEMREAD=1, EXRT=5, IDRS=5 -> exactly one cycle of PCHOLD=IFIDWRITE=IDEXFLUSH=1; EXRT=0 with IDRS=0 -> no stall.
REQ-034 SHALL cover: BRTAKEN pulse with LU also true, BRDELAY=1 -> IFFLASH=1 for 2 cycles, IDEXFLUSH=1 for 1 cycle, no PCHOLD, BUSY=1 for 1 cycle.
REQ-035 SHALL cover: MULSTART pulse with MULCYC=8 (macro on) -> PCHOLD=1 for 7 cycles; with MEMBUSY=1 for 3 cycles mid-wait -> PCHOLD=1 for 10 cycles, STALLCNT=10.
REQ-036 SHALL cover: RESET low during the 3rd MULWAIT cycle -> outputs 0 at once, STALLCNT=0, state RUN after release with no stall.
REQ-037 SHALL cover: STALLCNT preloaded by 65 540 continuous MEMBUSY cycles -> STALLCNT stays at 16'hFFFF.
REQ-038 SHALL cover: macro off, MULSTART pulse -> no output change, EXMEMFLUSH=0 throughout.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, branch flush, memory freeze and
// optional multi-cycle EX stall (enabled by macro PIPE_MULDIV_STALL_EN).
module pipe_hazard_ctrl #(
  parameter int unsigned MULCYC  = 8,
  parameter int unsigned BRDELAY = 1
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic [4:0]  IDRS,
  input  logic [4:0]  IDRT,
  input  logic        EXMEMREAD,
  input  logic [4:0]  EXRT,
  input  logic        BRTAKEN,
  input  logic        MEMBUSY,
  input  logic        MULSTART,
  output logic        PCHOLD,
  output logic        IFIDWRITE,
  output logic        IFFLASH,
  output logic        IDEXHOLD,
  output logic        IDEXFLUSH,
  output logic        EXMEMFLUSH,
  output logic        BUSY,
  output logic [15:0] STALLCNT
);

`ifdef PIPE_MULDIV_STALL_EN
  localparam int unsigned CW = 5;
`else
  localparam int unsigned CW = 3;
`endif

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    FLUSH   = 2'd1,
    MULWAIT = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [15:0]   stallcnt;
  logic          lu;
  logic          pchold_c, ifidwrite_c, ifflash_c, idexhold_c, idexflush_c;
`ifdef PIPE_MULDIV_STALL_EN
  logic          exmemflush_c;
`else
  logic          mul_unused;
  assign mul_unused = MULSTART & (MULCYC > 1);
`endif

  assign lu = EXMEMREAD & (EXRT != 5'd0) & ((EXRT == IDRS) | (EXRT == IDRT));

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    pchold_c    = 1'b0;
    ifidwrite_c = 1'b0;
    ifflash_c   = 1'b0;
    idexhold_c  = 1'b0;
    idexflush_c = 1'b0;
`ifdef PIPE_MULDIV_STALL_EN
    exmemflush_c = 1'b0;
`endif
    case (state)
      RUN: begin
        if (MEMBUSY) begin
          pchold_c    = 1'b1;
          ifidwrite_c = 1'b1;
          idexhold_c  = 1'b1;
        end else if (BRTAKEN) begin
          ifflash_c   = 1'b1;
          idexflush_c = 1'b1;
          if (BRDELAY > 0) begin
            state_nxt = FLUSH;
            cnt_nxt   = CW'(BRDELAY - 1);
          end
        end else if (lu) begin
          pchold_c    = 1'b1;
          ifidwrite_c = 1'b1;
          idexflush_c = 1'b1;
        end
`ifdef PIPE_MULDIV_STALL_EN
        else if (MULSTART) begin
          state_nxt = MULWAIT;
          cnt_nxt   = CW'(MULCYC - 2);
        end
`endif
      end
      FLUSH: begin
        ifflash_c = 1'b1;
        if (MEMBUSY) begin
          pchold_c    = 1'b1;
          ifidwrite_c = 1'b1;
          idexhold_c  = 1'b1;
        end else if (cnt == '0) begin
          state_nxt = RUN;
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
`ifdef PIPE_MULDIV_STALL_EN
      MULWAIT: begin
        pchold_c     = 1'b1;
        ifidwrite_c  = 1'b1;
        idexhold_c   = 1'b1;
        exmemflush_c = 1'b1;
        if (!MEMBUSY) begin
          if (cnt == '0) state_nxt = RUN;
          else           cnt_nxt   = cnt - CW'(1);
        end
      end
`endif
      default: begin
        state_nxt = RUN;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Outputs are gated by RESET so they clear immediately, even with live inputs.
  assign PCHOLD    = RESET & pchold_c;
  assign IFFLASH   = RESET & ifflash_c;
  assign IFIDWRITE = RESET & ifidwrite_c & ~ifflash_c;
  assign IDEXHOLD  = RESET & idexhold_c;
  assign IDEXFLUSH = RESET & idexflush_c;
  assign BUSY      = RESET & (state != RUN);
`ifdef PIPE_MULDIV_STALL_EN
  assign EXMEMFLUSH = RESET & exmemflush_c;
`else
  assign EXMEMFLUSH = 1'b0;
`endif

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET)                         stallcnt <= '0;
    else if (PCHOLD && stallcnt != '1)  stallcnt <= stallcnt + 16'd1;
  end

  assign STALLCNT = stallcnt;

endmodule
